// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : fir_channel_scheduler
// Purpose  : Round-robin sequencer sharing one FIR core between N_CH channels.
// Revision : 1.0 - initial release
// =============================================================================

module fir_channel_scheduler #(
    parameter int N_CH          = 4,
    parameter int BITWIDTH_DATA = 12,
    parameter int TIMEOUT       = 1023,
    localparam int CW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          EN,
    input  logic [N_CH-1:0]               CH_STRB,
    input  logic [N_CH*BITWIDTH_DATA-1:0] CH_DATA,
    output logic                          CORE_START,
    output logic [BITWIDTH_DATA-1:0]      CORE_DATA,
    output logic [CW-1:0]                 CORE_CH,
    input  logic                          CORE_DONE,
    input  logic [BITWIDTH_DATA-1:0]      CORE_RESULT,
    output logic                          OUT_VALID,
    output logic [BITWIDTH_DATA-1:0]      OUT_DATA,
    output logic [CW-1:0]                 OUT_CH,
    output logic [N_CH-1:0]               OVF,
    output logic                          ERR
);

    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [N_CH-1:0]          pend;
    logic [BITWIDTH_DATA-1:0] hold [N_CH];
    logic [CW-1:0]            last_grant;
    logic [CW-1:0]            gnt_ch;
    logic [CW-1:0]            sel_ch;
    logic                     sel_found;
    logic                     grant;
    logic                     timeout_hit;
    logic                     core_done_wait;
    logic [15:0]              count;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        sel_ch    = '0;
        sel_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!sel_found && pend[(int'(last_grant) + i) % N_CH]) begin
                sel_found = 1'b1;
                sel_ch    = CW'((int'(last_grant) + i) % N_CH);
            end
        end
    end

    assign grant          = (state == S_IDLE) && sel_found;
    assign timeout_hit    = (count == TO_LAST);
    assign core_done_wait = (state == S_WAIT) && CORE_DONE;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (sel_found) state_next = S_ISSUE;
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (CORE_DONE)        state_next = S_OUTPUT;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_OUTPUT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)    state <= S_IDLE;
        else if (!EN) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend       <= '0;
            last_grant <= LAST_CH;
            gnt_ch     <= '0;
            count      <= '0;
            CORE_START <= 1'b0;
            CORE_DATA  <= '0;
            CORE_CH    <= '0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_CH     <= '0;
            OVF        <= '0;
            ERR        <= 1'b0;
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
        end else if (!EN) begin
            pend       <= '0;
            last_grant <= LAST_CH;
            gnt_ch     <= '0;
            count      <= '0;
            CORE_START <= 1'b0;
            CORE_DATA  <= '0;
            CORE_CH    <= '0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_CH     <= '0;
            OVF        <= '0;
            ERR        <= 1'b0;
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
        end else begin
            // A strobe in the grant cycle refills the slot the grant just emptied.
            for (int k = 0; k < N_CH; k++) begin
                if (CH_STRB[k]) begin
                    if (!pend[k] || (grant && sel_ch == CW'(k))) begin
                        hold[k] <= CH_DATA[k*BITWIDTH_DATA +: BITWIDTH_DATA];
                        pend[k] <= 1'b1;
                    end else begin
                        OVF[k]  <= 1'b1;
                    end
                end else if (grant && sel_ch == CW'(k)) begin
                    pend[k] <= 1'b0;
                end
            end

            CORE_START <= grant;
            CORE_DATA  <= grant ? hold[sel_ch] : '0;
            CORE_CH    <= grant ? sel_ch : '0;
            if (grant) begin
                gnt_ch     <= sel_ch;
                last_grant <= sel_ch;
            end

            if (state == S_ISSUE)     count <= '0;
            else if (state == S_WAIT) count <= count + 16'd1;

            OUT_VALID <= core_done_wait;
            if (core_done_wait) begin
                OUT_DATA <= CORE_RESULT;
                OUT_CH   <= gnt_ch;
            end

            if ((state == S_WAIT) && !CORE_DONE && timeout_hit) ERR <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_fir_channel_scheduler
// Purpose  : Directed scoreboard bench for fir_channel_scheduler with a core model.
// Revision : 1.0 - initial release
// =============================================================================

module tb_fir_channel_scheduler;

    localparam int N_CH = 4;
    localparam int BW   = 12;
    localparam int CW   = 2;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              EN;
    logic [N_CH-1:0]   CH_STRB;
    logic [N_CH*BW-1:0] CH_DATA;
    logic              CORE_START;
    logic [BW-1:0]     CORE_DATA;
    logic [CW-1:0]     CORE_CH;
    logic              CORE_DONE;
    logic [BW-1:0]     CORE_RESULT;
    logic              OUT_VALID;
    logic [BW-1:0]     OUT_DATA;
    logic [CW-1:0]     OUT_CH;
    logic [N_CH-1:0]   OVF;
    logic              ERR;

    fir_channel_scheduler #(
        .N_CH          (N_CH),
        .BITWIDTH_DATA (BW),
        .TIMEOUT       (8)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .EN          (EN),
        .CH_STRB     (CH_STRB),
        .CH_DATA     (CH_DATA),
        .CORE_START  (CORE_START),
        .CORE_DATA   (CORE_DATA),
        .CORE_CH     (CORE_CH),
        .CORE_DONE   (CORE_DONE),
        .CORE_RESULT (CORE_RESULT),
        .OUT_VALID   (OUT_VALID),
        .OUT_DATA    (OUT_DATA),
        .OUT_CH      (OUT_CH),
        .OVF         (OVF),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [BW-1:0] data;
    } exp_t;

    exp_t exp_issue [$];
    exp_t exp_out   [$];
    exp_t ei;
    exp_t eo;

    // Core model: fixed latency 2, result = sample ^ 0x188, per-channel enable.
    logic [N_CH-1:0] resp_mask = '1;
    int              core_cnt   = 0;
    logic            model_done = 1'b0;
    logic [BW-1:0]   core_res   = '0;
    logic            tb_done    = 1'b0;

    assign CORE_DONE   = model_done | tb_done;
    assign CORE_RESULT = core_res;

    always @(posedge CLK) begin
        #1;
        model_done <= (core_cnt == 1);
        if (CORE_START && resp_mask[CORE_CH]) begin
            core_cnt <= 2;
            core_res <= CORE_DATA ^ 12'h188;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST && CORE_START) begin
            if (exp_issue.size() == 0) begin
                check("unexpected_issue", 32'(CORE_CH), 32'hFFFF_FFFF);
            end else begin
                ei = exp_issue.pop_front();
                check("core_ch", 32'(CORE_CH), 32'(ei.ch));
                check("core_data", 32'(CORE_DATA), 32'(ei.data));
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST && OUT_VALID) begin
            if (exp_out.size() == 0) begin
                check("unexpected_out", 32'(OUT_CH), 32'hFFFF_FFFF);
            end else begin
                eo = exp_out.pop_front();
                check("out_ch", 32'(OUT_CH), 32'(eo.ch));
                check("out_data", 32'(OUT_DATA), 32'(eo.data));
            end
        end
    end

    task automatic push_io(input logic [CW-1:0] ch, input logic [BW-1:0] d, input bit with_out);
        exp_issue.push_back({ch, d});
        if (with_out) exp_out.push_back({ch, d ^ 12'h188});
    endtask

    function automatic logic [N_CH*BW-1:0] bus(input logic [BW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobe(input logic [N_CH-1:0] m, input logic [N_CH*BW-1:0] d);
        CH_STRB = m;
        CH_DATA = d;
        @(posedge CLK);
        #1;
        CH_STRB = '0;
        CH_DATA = '0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_issue.size() != 0 || exp_out.size() != 0) && n < maxc) begin
            @(posedge CLK);
            n++;
        end
        check("drain_pending", 32'(exp_issue.size() + exp_out.size()), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s;

    initial begin
        nRST = 1'b0; EN = 1'b1; CH_STRB = '0; CH_DATA = '0;
        @(posedge CLK);
        #1;
        check("rst_core", 32'({CORE_START, CORE_DATA, CORE_CH}), 32'd0);
        check("rst_out", 32'({OUT_VALID, OUT_DATA, OUT_CH}), 32'd0);
        check("rst_flags", 32'({OVF, ERR}), 32'd0);
        at_cycle(3);
        nRST = 1'b1;

        // Single transaction with exact cycle timing.
        at_cycle(10);
        push_io(2'd2, 12'h123, 1'b1);
        strobe(4'b0100, bus(12'h0, 12'h0, 12'h123, 12'h0));
        check("t1_no_start_c11", 32'(CORE_START), 32'd0);
        at_cycle(12);
        check("t1_start_c12", 32'({CORE_START, CORE_CH, CORE_DATA}), 32'({1'b1, 2'd2, 12'h123}));
        at_cycle(13);
        check("t1_core_idle_c13", 32'({CORE_START, CORE_CH, CORE_DATA}), 32'd0);
        at_cycle(14);
        check("t1_no_out_c14", 32'(OUT_VALID), 32'd0);
        at_cycle(15);
        check("t1_out_c15", 32'({OUT_VALID, OUT_CH, OUT_DATA}), 32'({1'b1, 2'd2, 12'h0AB}));
        at_cycle(16);
        check("t1_out_hold_c16", 32'({OUT_VALID, OUT_DATA}), 32'({1'b0, 12'h0AB}));
        drain(40);

        // Two full waves after reset: ch0..ch3 order both times, no overrun.
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) push_io(CW'(k), 12'(12'h101 * (k + 1)), 1'b1);
        strobe(4'hF, bus(12'h101, 12'h202, 12'h303, 12'h404));
        drain(60);
        check("wave1_ovf", 32'(OVF), 32'd0);
        for (int k = 0; k < 4; k++) push_io(CW'(k), 12'(12'h5A5 + 12'h111 * k), 1'b1);
        strobe(4'hF, bus(12'h5A5, 12'h6B6, 12'h7C7, 12'h8D8));
        drain(60);
        check("wave2_ovf", 32'(OVF), 32'd0);

        // Strobe in the channel's own grant cycle: both samples issued.
        push_io(2'd1, 12'h011, 1'b1);
        push_io(2'd1, 12'h077, 1'b1);
        strobe(4'b0010, bus(12'h0, 12'h011, 12'h0, 12'h0));
        strobe(4'b0010, bus(12'h0, 12'h077, 12'h0, 12'h0));
        drain(40);
        check("grant_cycle_ovf", 32'(OVF), 32'd0);

        // Overrun on ch1 while ch0 occupies the core.
        s = cyc;
        push_io(2'd0, 12'h0A0, 1'b1);
        push_io(2'd1, 12'h011, 1'b1);
        strobe(4'b0011, bus(12'h0A0, 12'h011, 12'h0, 12'h0));
        at_cycle(s + 3);
        strobe(4'b0010, bus(12'h0, 12'h055, 12'h0, 12'h0));
        check("ovr_flag", 32'(OVF), 32'b0010);
        drain(40);
        check("ovr_sticky", 32'(OVF), 32'b0010);

        // Core timeout on ch2, then ch3 proceeds.
        resp_mask = 4'b1011;
        s = cyc;
        push_io(2'd2, 12'h222, 1'b0);
        push_io(2'd3, 12'h333, 1'b1);
        strobe(4'b1100, bus(12'h0, 12'h0, 12'h222, 12'h333));
        at_cycle(s + 10);
        check("to_err_early", 32'(ERR), 32'd0);
        at_cycle(s + 11);
        check("to_err_set", 32'(ERR), 32'd1);
        at_cycle(s + 12);
        check("to_next_issue", 32'({CORE_START, CORE_CH}), 32'({1'b1, 2'd3}));
        drain(40);
        check("to_err_sticky", 32'(ERR), 32'd1);
        resp_mask = '1;

        // EN low for one cycle during OUTPUT clears everything.
        s = cyc;
        push_io(2'd0, 12'h0F0, 1'b1);
        strobe(4'b0011, bus(12'h0F0, 12'h111, 12'h0, 12'h0));
        at_cycle(s + 3);
        strobe(4'b0010, bus(12'h0, 12'h155, 12'h0, 12'h0));
        check("en_pre_flags", 32'({OVF, ERR}), 32'({4'b0010, 1'b1}));
        at_cycle(s + 5);
        check("en_in_output", 32'({OUT_VALID, OUT_CH}), 32'({1'b1, 2'd0}));
        EN = 1'b0;
        @(posedge CLK);
        #1;
        EN = 1'b1;
        check("en_out_cleared", 32'({OUT_VALID, OUT_DATA, OUT_CH}), 32'd0);
        check("en_flags_cleared", 32'({OVF, ERR}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            check("en_pend_cleared", 32'(CORE_START), 32'd0);
        end
        s = cyc;
        push_io(2'd3, 12'h3C3, 1'b1);
        strobe(4'b1000, bus(12'h0, 12'h0, 12'h0, 12'h3C3));
        at_cycle(s + 2);
        check("en_fresh_issue", 32'({CORE_START, CORE_CH, CORE_DATA}), 32'({1'b1, 2'd3, 12'h3C3}));
        drain(40);

        // Asynchronous reset during WAIT, then a stray done.
        resp_mask = 4'b1110;
        s = cyc;
        push_io(2'd0, 12'h0C0, 1'b0);
        strobe(4'b0001, bus(12'h0C0, 12'h0, 12'h0, 12'h0));
        at_cycle(s + 3);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_core", 32'({CORE_START, CORE_DATA, CORE_CH}), 32'd0);
        check("arst_out", 32'({OUT_VALID, OUT_DATA, OUT_CH}), 32'd0);
        check("arst_flags", 32'({OVF, ERR}), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        tb_done = 1'b1;
        @(posedge CLK);
        #1;
        tb_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_done_ignored", 32'(OUT_VALID), 32'd0);
            @(posedge CLK);
            #1;
        end
        check("final_queues", 32'(exp_issue.size() + exp_out.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
